// File: rtl/cpu_ahb_sram_slave.sv
// rtl/cpu_ahb_sram_slave.sv - AHB-Lite on-chip SRAM responder for the CPU system-bus master port
//
// Purpose: register-array memory window at ADDR_BASE with byte/half/word
// access, WAIT_STATES wait cycles per OKAY data phase, and the two-cycle
// ERROR response for out-of-window, oversize or misaligned accesses.
//
// Ports:
//   cpu_clk, pad_cpu_rst_b           clock, asynchronous active-low reset
//   biu_pad_haddr/hsize/htrans/hwrite address-phase controls from the master
//   biu_pad_hburst/hprot              accepted but ignored
//   biu_pad_hwdata                    data-phase write data (little-endian lanes)
//   pad_biu_hrdata/hready/hresp       data-phase response to the master
//   slv_err_cnt                       saturating count of ERROR responses
module cpu_ahb_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10,
  parameter int          WAIT_STATES = 0
) (
  input  logic        cpu_clk,
  input  logic        pad_cpu_rst_b,
  input  logic [31:0] biu_pad_haddr,
  input  logic [2:0]  biu_pad_hburst,
  input  logic [3:0]  biu_pad_hprot,
  input  logic [2:0]  biu_pad_hsize,
  input  logic [1:0]  biu_pad_htrans,
  input  logic [31:0] biu_pad_hwdata,
  input  logic        biu_pad_hwrite,
  output logic [31:0] pad_biu_hrdata,
  output logic        pad_biu_hready,
  output logic [1:0]  pad_biu_hresp,
  output logic [7:0]  slv_err_cnt
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic [2:0]    wait_cnt;
  logic          sample;
  logic          in_win;
  logic          size_ok;
  logic          legal;
  logic [3:0]    byte_en;
  logic [AW-1:0] word_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Burst/protection carry no meaning here; htrans[0] only separates
  // IDLE/BUSY and NONSEQ/SEQ, both of which are handled identically.
  logic unused_inputs;
  assign unused_inputs = ^{biu_pad_hburst, biu_pad_hprot, biu_pad_htrans[0]};

  assign pad_biu_hready = (state != ST_WAIT) && (state != ST_ERR1);
  assign pad_biu_hresp  = {1'b0, (state == ST_ERR1) || (state == ST_ERR2)};

  assign sample = pad_biu_hready && biu_pad_htrans[1];

  // The window is aligned to its own size, so membership is a compare of
  // the bits above the word index.
  assign in_win  = (biu_pad_haddr[31:AW+2] == ADDR_BASE[31:AW+2]);
  assign size_ok = (biu_pad_hsize <= 3'd2)
                && !((biu_pad_hsize == 3'd1) && biu_pad_haddr[0])
                && !((biu_pad_hsize == 3'd2) && (biu_pad_haddr[1:0] != 2'b00));
  assign legal   = in_win && size_ok;

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (sample) begin
          if (!legal)
            state_nxt = ST_ERR1;
          else if (WAIT_STATES > 0)
            state_nxt = ST_WAIT;
          else
            state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: state_nxt = (wait_cnt == 3'd1) ? ST_DATA : ST_WAIT;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= 2'd0;
      write_q     <= 1'b0;
      wait_cnt    <= 3'd0;
      slv_err_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      // sample only happens while hready=1, i.e. never in WAIT, so the
      // reload and the decrement cannot collide.
      if (sample) begin
        addr_q   <= biu_pad_haddr[AW+1:0];
        size_q   <= biu_pad_hsize[1:0];
        write_q  <= biu_pad_hwrite;
        wait_cnt <= 3'(WAIT_STATES);
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if ((state == ST_ERR2) && (slv_err_cnt != 8'hff))
        slv_err_cnt <= slv_err_cnt + 8'd1;
    end
  end

  assign word_idx = addr_q[AW+1:2];

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << addr_q[1:0];
      2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory is not reset; a reset during a transfer forces state to IDLE
  // asynchronously, so an abandoned write never reaches this block.
  always_ff @(posedge cpu_clk) begin
    if ((state == ST_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[word_idx][8*b +: 8] <= biu_pad_hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    pad_biu_hrdata = 32'h0;
    if ((state == ST_DATA) && !write_q)
      pad_biu_hrdata = mem[word_idx];
  end

endmodule

// File: tb/tb_cpu_ahb_sram_slave.sv
// tb/tb_cpu_ahb_sram_slave.sv - self-checking bench for cpu_ahb_sram_slave at 0, 2 and 3 wait states
module tb_cpu_ahb_sram_slave;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int DW = 1024;
  localparam int WS [3] = '{0, 2, 3};

  logic        clk = 1'b0;
  logic        rst_b  [3];
  logic [31:0] haddr  [3];
  logic [2:0]  hburst [3];
  logic [3:0]  hprot  [3];
  logic [2:0]  hsize  [3];
  logic [1:0]  htrans [3];
  logic [31:0] hwdata [3];
  logic        hwrite [3];
  logic [31:0] hrdata [3];
  logic        hready [3];
  logic [1:0]  hresp  [3];
  logic [7:0]  ecnt   [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_ahb_sram_slave #(
      .ADDR_BASE(BASE), .DEPTH_WORDS(DW), .AW(10), .WAIT_STATES(WS[g])
    ) u_dut (
      .cpu_clk(clk), .pad_cpu_rst_b(rst_b[g]),
      .biu_pad_haddr(haddr[g]), .biu_pad_hburst(hburst[g]), .biu_pad_hprot(hprot[g]),
      .biu_pad_hsize(hsize[g]), .biu_pad_htrans(htrans[g]), .biu_pad_hwdata(hwdata[g]),
      .biu_pad_hwrite(hwrite[g]), .pad_biu_hrdata(hrdata[g]), .pad_biu_hready(hready[g]),
      .pad_biu_hresp(hresp[g]), .slv_err_cnt(ecnt[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Per instance: the one outstanding transfer (if any) and how many
  // cycles of its data phase have elapsed.
  bit          m_act [3];
  bit          m_leg [3];
  bit          m_wr  [3];
  logic [31:0] m_addr[3];
  logic [2:0]  m_size[3];
  int          m_k   [3];
  int          m_cnt [3];
  logic [31:0] mm [3][DW];

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 4 * DW) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1 && a[0]) return 1'b0;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit lane_hit(input logic [2:0] s, input logic [31:0] a, input int b);
    if (s == 3'd0) return b == int'(a[1:0]);
    if (s == 3'd1) return (b / 2) == int'(a[1]);
    return 1'b1;
  endfunction

  // Length of the data phase in cycles minus one: WAIT_STATES for OKAY, 1 for ERROR.
  function automatic bit last_cycle(input int i);
    if (!m_act[i]) return 1'b1;
    return m_leg[i] ? (m_k[i] == WS[i]) : (m_k[i] == 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_b[i]) begin
        m_act[i] <= 1'b0;
        m_cnt[i] <= 0;
      end else begin
        if (m_act[i] && m_leg[i] && m_wr[i] && last_cycle(i))
          for (int b = 0; b < 4; b++)
            if (lane_hit(m_size[i], m_addr[i], b))
              mm[i][m_addr[i][11:2]][8*b +: 8] <= hwdata[i][8*b +: 8];
        if (m_act[i] && !m_leg[i] && last_cycle(i) && m_cnt[i] < 255)
          m_cnt[i] <= m_cnt[i] + 1;
        if (last_cycle(i)) begin
          m_act[i]  <= htrans[i][1];
          m_leg[i]  <= is_legal(haddr[i], hsize[i]);
          m_wr[i]   <= hwrite[i];
          m_addr[i] <= haddr[i];
          m_size[i] <= hsize[i];
          m_k[i]    <= 0;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic        e_rdy;
      logic [1:0]  e_rsp;
      logic [31:0] e_dat;
      logic [7:0]  e_cnt;
      e_rdy = 1'b1; e_rsp = 2'b00; e_dat = 32'h0;
      e_cnt = rst_b[i] ? 8'(m_cnt[i]) : 8'd0;
      if (rst_b[i] && m_act[i]) begin
        if (m_leg[i]) begin
          e_rdy = (m_k[i] == WS[i]);
          if (e_rdy && !m_wr[i]) e_dat = mm[i][m_addr[i][11:2]];
        end else begin
          e_rdy = (m_k[i] == 1);
          e_rsp = 2'b01;
        end
      end
      chk($sformatf("hready[%0d]", i), 32'(hready[i]), 32'(e_rdy));
      chk($sformatf("hresp[%0d]", i),  32'(hresp[i]),  32'(e_rsp));
      chk($sformatf("hrdata[%0d]", i), hrdata[i], e_dat);
      chk($sformatf("err_cnt[%0d]", i), 32'(ecnt[i]), 32'(e_cnt));
    end
  end

  // ---------------- stimulus ----------------
  // Present an address phase, wait for the edge that accepts it, then drive
  // the write data for its data phase and return #1 after that edge.
  task automatic step(input int i, input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] s, input logic w, input logic [31:0] wd);
    int n;
    htrans[i] = tr; haddr[i] = a; hsize[i] = s; hwrite[i] = w;
    hburst[i] = 3'($urandom); hprot[i] = 4'($urandom);
    n = 0;
    while (!hready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk($sformatf("accept_timeout[%0d]", i), 32'(hready[i]), 32'd1);
    @(posedge clk);
    #1;
    hwdata[i] = wd;
    htrans[i] = 2'd0;
  endtask

  // Follow an accepted OKAY data phase to completion; returns at the negedge
  // of its final (hready=1) cycle.
  task automatic finish(input int i, input string nm, input int expw,
                        input bit chk_rd, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!hready[i] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_waits"}, 32'(n), 32'(expw));
    if (chk_rd) chk(nm, hrdata[i], exp);
  endtask

  task automatic err_seq(input int i, input string nm);
    @(negedge clk);
    chk({nm, "_c1_rdy"}, 32'(hready[i]), 32'd0);
    chk({nm, "_c1_rsp"}, 32'(hresp[i]), 32'd1);
    @(negedge clk);
    chk({nm, "_c2_rdy"}, 32'(hready[i]), 32'd1);
    chk({nm, "_c2_rsp"}, 32'(hresp[i]), 32'd1);
    chk({nm, "_c2_dat"}, hrdata[i], 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_b[i] = 1'b0; haddr[i] = BASE; hburst[i] = 3'd0; hprot[i] = 4'd0;
      hsize[i] = 3'd2; htrans[i] = 2'd0; hwdata[i] = 32'h0; hwrite[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready", 32'(hready[0]), 32'd1);
    chk("rst_hresp", 32'(hresp[0]), 32'd0);
    chk("rst_hrdata", hrdata[0], 32'd0);
    chk("rst_errcnt", 32'(ecnt[2]), 32'd0);
    for (int i = 0; i < 3; i++) rst_b[i] = 1'b1;

    // Give every word a defined value.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < DW; w++)
        step(i, 2'd2, BASE + 32'(4 * w), 3'd2, 1'b1, $urandom);
    repeat (5) @(posedge clk);
    #1;

    // Zero wait states: word write/read, lane merges.
    step(0, 2'd2, BASE, 3'd2, 1'b1, 32'hCAFE_F00D);
    step(0, 2'd2, BASE + 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
    step(0, 2'd2, BASE + 32'h10, 3'd2, 1'b0, 32'h0);
    finish(0, "t1_word_rd", 0, 1'b1, 32'hDEAD_BEEF);
    step(0, 2'd2, BASE + 32'h11, 3'd0, 1'b1, 32'h0000_AB00);
    step(0, 2'd3, BASE + 32'h12, 3'd1, 1'b1, 32'h1234_5678);
    step(0, 2'd2, BASE + 32'h10, 3'd2, 1'b0, 32'h0);
    finish(0, "t2_merge_rd", 0, 1'b1, 32'h1234_ABEF);

    // Out-of-window write, then the base word must be intact.
    step(0, 2'd2, BASE + 32'(4 * DW), 3'd2, 1'b1, 32'h5555_5555);
    err_seq(0, "t3_oob");
    @(negedge clk);
    chk("t3_errcnt", 32'(ecnt[0]), 32'd1);
    step(0, 2'd2, BASE, 3'd2, 1'b0, 32'h0);
    finish(0, "t3_base_rd", 0, 1'b1, 32'hCAFE_F00D);

    // Misaligned word and oversize accesses, back to back.
    step(0, 2'd2, BASE + 32'h2, 3'd2, 1'b0, 32'h0);
    err_seq(0, "t4_misal");
    step(0, 2'd2, BASE, 3'd3, 1'b0, 32'h0);
    err_seq(0, "t4_size3");
    @(negedge clk);
    chk("t4_errcnt", 32'(ecnt[0]), 32'd3);

    // Two wait states, pipelined write then read.
    step(1, 2'd2, BASE + 32'h20, 3'd2, 1'b1, 32'hA5C3_0F96);
    step(1, 2'd2, BASE + 32'h20, 3'd2, 1'b0, 32'h0);
    finish(1, "t5_rd", 2, 1'b1, 32'hA5C3_0F96);

    // Three wait states, reset in the second wait cycle abandons the write.
    step(2, 2'd2, BASE + 32'h40, 3'd2, 1'b1, 32'h1111_1111);
    finish(2, "t6_pre", 3, 1'b0, 32'h0);
    step(2, 2'd2, BASE + 32'h40, 3'd2, 1'b1, 32'h2222_2222);
    @(posedge clk);
    #2;
    rst_b[2] = 1'b0;
    #1;
    chk("t6_rst_hready", 32'(hready[2]), 32'd1);
    chk("t6_rst_hresp", 32'(hresp[2]), 32'd0);
    chk("t6_rst_hrdata", hrdata[2], 32'd0);
    @(posedge clk);
    #1;
    rst_b[2] = 1'b1;
    step(2, 2'd2, BASE + 32'h40, 3'd2, 1'b0, 32'h0);
    finish(2, "t6_old_rd", 3, 1'b1, 32'h1111_1111);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, last_a;
      logic [2:0]  s;
      logic [1:0]  tr;
      int r;
      last_a = BASE;
      for (int n = 0; n < 300; n++) begin
        r  = int'($urandom % 16);
        s  = ($urandom % 8 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
        tr = ($urandom % 4 == 0) ? 2'($urandom % 2) : 2'(2 + $urandom % 2);
        a  = BASE + 32'(($urandom % DW) * 4);
        if (s == 3'd0) a = a + 32'($urandom % 4);
        if (s == 3'd1) a = a + 32'(2 * ($urandom % 2));
        case (r)
          0: a = BASE + 32'(4 * DW) + 32'($urandom % 64);
          1: a = BASE - 32'(1 + $urandom % 8);
          2: a = a + 32'($urandom % 4);
          3, 4: a = last_a;
          default: ;
        endcase
        last_a = a;
        step(i, tr, a, s, 1'($urandom), $urandom);
      end
      repeat (6) @(posedge clk);
      #1;
    end

    // Drive the error counter into saturation.
    for (int n = 0; n < 260; n++)
      step(0, 2'd2, BASE + 32'(4 * DW), 3'd2, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    chk("sat_errcnt", 32'(ecnt[0]), 32'd255);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
